// File: rtl/paralelo_serial_tx_pkg.sv
// Shared definitions for the serial link transmit side: character width,
// the COM sync/idle character and the transmitter state encoding.
package paralelo_serial_tx_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COM_CHAR = 8'hBC;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/paralelo_serial_tx_piso_byte.sv
// 8-bit parallel-in serial-out shift register, MSB first. Resets to the COM
// character so the line shows a valid sync bit as soon as reset asserts.
module piso_byte
    import paralelo_serial_tx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BYTE_W-1:0] din,
    output logic              dout
);

    logic [BYTE_W-1:0] shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= COM_CHAR;
        end else if (load) begin
            shreg <= din;
        end else begin
            shreg <= {shreg[BYTE_W-2:0], 1'b0};
        end
    end

    assign dout = shreg[BYTE_W-1];

endmodule

// File: rtl/paralelo_serial_tx.sv
// Serial link transmitter: COM preamble after reset, then 32-bit words sent
// MSB-first one bit per clock, with COM as the idle character.
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SYNC_COUNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              active_tx
);

    localparam int LANES  = DATA_W / BYTE_W;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SYNC_W = $clog2(SYNC_COUNT + 1);
    localparam int BIT_W  = $clog2(BYTE_W);

    tx_state_t         state, state_d;
    logic [SYNC_W-1:0] sync_cnt, sync_cnt_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [IDX_W-1:0]  byte_idx, byte_idx_d;
    logic [DATA_W-1:0] hold, hold_d;
    logic              hold_full, hold_full_d;
    logic              boundary;
    logic              capture;
    logic              load;
    logic [BYTE_W-1:0] load_byte;

    assign boundary  = (bit_cnt == BIT_W'(BYTE_W - 1));
    assign ready_out = (state == RUN) && !hold_full;
    assign active_tx = (state == RUN);
    assign capture   = valid_in && ready_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            sync_cnt  <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_d;
            sync_cnt  <= sync_cnt_d;
            bit_cnt   <= bit_cnt_d;
            byte_idx  <= byte_idx_d;
            hold      <= hold_d;
            hold_full <= hold_full_d;
        end
    end

    // Boundary decisions use pre-edge hold_full, so a word captured on a
    // boundary edge waits for the next one. Capture never coincides with the
    // byte-3 clear because ready_out is low while hold_full is set.
    always_comb begin
        state_d     = state;
        sync_cnt_d  = sync_cnt;
        bit_cnt_d   = bit_cnt + BIT_W'(1);
        byte_idx_d  = byte_idx;
        hold_d      = hold;
        hold_full_d = hold_full;
        load        = 1'b0;
        load_byte   = COM_CHAR;

        if (boundary) begin
            load = 1'b1;
            case (state)
                SYNC: begin
                    sync_cnt_d = sync_cnt + SYNC_W'(1);
                    if (sync_cnt == SYNC_W'(SYNC_COUNT - 1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (hold_full) begin
                        load_byte  = hold[(DATA_W - 1 - BYTE_W * int'(byte_idx)) -: BYTE_W];
                        byte_idx_d = byte_idx + IDX_W'(1);
                        if (byte_idx == IDX_W'(LANES - 1)) begin
                            byte_idx_d  = '0;
                            hold_full_d = 1'b0;
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        if (capture) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
    end

    piso_byte u_piso_byte (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .din   (load_byte),
        .dout  (data_out)
    );

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: a character-level model (queue
// of pending bytes, edge counter) predicts line bits, ready and active.
module tb_paralelo_serial_tx;

    localparam int SYNC_COUNT = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        data_out;
    logic        active_tx;

    int compared = 0;
    int mismatched = 0;

    // Model: edges since reset release, character on the line, bytes waiting
    int         n_edges;
    logic [7:0] cur_char;
    logic [7:0] pending[$];

    always #5 clk = ~clk;

    paralelo_serial_tx #(.DATA_W(32), .SYNC_COUNT(SYNC_COUNT)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .active_tx (active_tx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at t=%0t edge=%0d: got %h, want %h", tag, $time, n_edges, obs, exp);
        end
    endtask

    function automatic logic modelActive();
        return n_edges >= 8 * SYNC_COUNT;
    endfunction

    function automatic logic modelReady();
        return modelActive() && (pending.size() == 0);
    endfunction

    task automatic modelReset();
        n_edges  = 0;
        cur_char = COM;
        pending.delete();
    endtask

    task automatic checkLine(input string tag);
        int pos;
        pos = n_edges % 8;
        checkOutput({tag, ".data_out"}, 32'(data_out), 32'(cur_char[7 - pos]));
        checkOutput({tag, ".ready_out"}, 32'(ready_out), 32'(modelReady()));
        checkOutput({tag, ".active_tx"}, 32'(active_tx), 32'(modelActive()));
    endtask

    // One clock: drive inputs, advance the model across the edge, check after.
    task automatic applyStimulus(input logic v, input logic [31:0] d, output logic cap);
        valid_in = v;
        data_in  = d;
        cap = v && modelReady();
        n_edges++;
        if (n_edges % 8 == 0) begin
            if (n_edges <= 8 * SYNC_COUNT) cur_char = COM;
            else if (pending.size() != 0) cur_char = pending.pop_front();
            else cur_char = COM;
        end
        if (cap) begin
            pending.push_back(d[31:24]);
            pending.push_back(d[23:16]);
            pending.push_back(d[15:8]);
            pending.push_back(d[7:0]);
        end
        @(posedge clk);
        @(negedge clk);
        checkLine("cyc");
    endtask

    task automatic idle(input int cycles);
        logic c;
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, c);
    endtask

    // Present a word and hold it until accepted, bounded by a cycle budget.
    task automatic sendWord(input logic [31:0] w, input string tag);
        logic c;
        int   k;
        c = 1'b0;
        k = 0;
        while (!c && k < 200) begin
            applyStimulus(1'b1, w, c);
            k++;
        end
        valid_in = 1'b0;
        if (!c) checkOutput({tag, ".accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic applyReset();
        valid_in = 1'b0;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("reset.data_out", 32'(data_out), 32'd1);
        checkOutput("reset.ready_out", 32'(ready_out), 32'd0);
        checkOutput("reset.active_tx", 32'(active_tx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic c;
        int   k;

        // 1: preamble then idle COM
        @(negedge clk);
        applyReset();
        idle(32);
        checkOutput("t1.active_after_32", 32'(active_tx), 32'd1);
        checkOutput("t1.ready_after_32", 32'(ready_out), 32'd1);
        idle(16);

        // 2: single word, then idle
        idle($urandom_range(0, 7));
        sendWord(32'hDEADBEEF, "t2");
        checkOutput("t2.ready_low_after_capture", 32'(ready_out), 32'd0);
        idle(48);

        // 3: valid held across the whole preamble
        applyReset();
        sendWord(32'h12345678, "t3");
        checkOutput("t3.captured_at_edge", 32'(n_edges), 32'(8 * SYNC_COUNT + 1));
        idle(48);

        // 4: capture exactly on a boundary edge
        k = 0;
        while (!(((n_edges + 1) % 8 == 0) && modelReady()) && k < 64) begin
            applyStimulus(1'b0, '0, c);
            k++;
        end
        applyStimulus(1'b1, 32'hA5C3_0FF0, c);
        valid_in = 1'b0;
        checkOutput("t4.boundary_capture", 32'(c), 32'd1);
        checkOutput("t4.com_sent_on_boundary", 32'(cur_char), 32'(COM));
        idle(48);

        // 5: back-to-back words with no COM between them
        sendWord(32'h00000000, "t5a");
        sendWord(32'hFFFFFFFF, "t5b");
        checkOutput("t5.second_in_gap_window", 32'(pending.size()), 32'd4);
        idle(48);

        // 6: reset mid-word
        sendWord(32'hCAFEF00D, "t6");
        k = 0;
        while (pending.size() != 1 && k < 64) begin
            applyStimulus(1'b0, '0, c);
            k++;
        end
        idle(3);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("t6.async_data_out", 32'(data_out), 32'd1);
        checkOutput("t6.async_ready_out", 32'(ready_out), 32'd0);
        checkOutput("t6.async_active_tx", 32'(active_tx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(48);

        // Random traffic with random gaps and upstream holding each word
        for (int w = 0; w < 12; w++) begin
            idle($urandom_range(0, 12));
            sendWord($urandom, "rand");
        end
        idle(48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
